// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl (with leaf cells sum1, carry1)
// Purpose  : Bit-serial adder sequencer. It adds two WIDTH-bit unsigned
//            operands one bit per clock, LSB first. The datapath is built
//            from a single sum1 cell and a single carry1 cell. A
//            start/busy/done handshake frames each addition.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            start - request, accepted only while idle
//            a, b  - WIDTH-bit operands, latched on acceptance
//            cin   - carry-in, latched on acceptance
//            busy  - high while an addition is in flight (RUN and DONE)
//            done  - one-cycle pulse; s/cout valid
//            s     - WIDTH-bit sum register
//            cout  - final carry-out register
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// sum1 : single-bit full-adder sum cell
// ----------------------------------------------------------------------------
module sum1 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s
);
   assign s = a ^ b ^ c;
endmodule

// ----------------------------------------------------------------------------
// carry1 : single-bit full-adder carry cell
// ----------------------------------------------------------------------------
module carry1 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic z
);
   assign z = (a & b) | (c & (a ^ b));
endmodule

// ----------------------------------------------------------------------------
// serial_adder_ctrl : sequencer top
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   // The counter is one bit wider than the index range so that it can
   // reach WIDTH without wrapping.
   localparam int              CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;

   logic             sum_bit;
   logic             carry_bit;
   logic             last_bit;
   logic [WIDTH-1:0] acc_shift;

   // ------------------------------------------------------------------
   // 1-bit datapath: the current LSBs of the operand shifters and the
   // carry flop feed the two cells.
   // ------------------------------------------------------------------
   sum1 u_sum1 (
      .a (sa_q[0]),
      .b (sb_q[0]),
      .c (carry_q),
      .s (sum_bit)
   );

   carry1 u_carry1 (
      .a (sa_q[0]),
      .b (sb_q[0]),
      .c (carry_q),
      .z (carry_bit)
   );

   // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
   // result has reached bit 0 of the accumulator.
   generate
      if (WIDTH == 1) begin : g_acc_w1
         assign acc_shift = sum_bit;
      end else begin : g_acc_wn
         assign acc_shift = {sum_bit, acc_q[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt_q == LAST_BIT);

   // ------------------------------------------------------------------
   // FSM: state register (also registers busy/done)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic. It is decoded from the next state so that busy
   // and done come straight from flops and stay aligned with the state.
   // ------------------------------------------------------------------
   always_comb begin
      busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // ------------------------------------------------------------------
   // Operand, carry, counter, accumulator and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q    <= '0;
         sb_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
               end
            end
            ST_RUN: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               acc_q   <= acc_shift;
               carry_q <= carry_bit;
               cnt_q   <= cnt_q + CW'(1);
               // The result registers are written only here. They hold the
               // previous result through IDLE and through the next RUN.
               if (last_bit) begin
                  s_q    <= acc_shift;
                  cout_q <= carry_bit;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Purpose  : Directed self-checking bench for serial_adder_ctrl. It
//            instantiates a WIDTH=1 copy and a WIDTH=8 copy, and each copy
//            is compared against hand-computed sums and handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] s8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] s1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .s(s8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .s(s1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge. Inputs are driven and
   // outputs are sampled there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one WIDTH=8 addition. Observation i=0 is taken right after the
   // accepting edge k. The task records the done latency, the number of
   // busy and done cycles, the captured result, and whether s held its old
   // value until done.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      output int lat, output int nbusy, output int ndone,
                      output logic [7:0] rs, output logic rc, output logic held);
      logic [7:0] s_prev;
      a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      s_prev = s8;
      lat = -1; nbusy = 0; ndone = 0; held = 1'b1; rs = '0; rc = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (busy8) nbusy++;
         if (done8) begin
            ndone++;
            if (lat < 0) begin
               lat = i; rs = s8; rc = cout8;
            end
         end else if (ndone == 0 && s8 !== s_prev) begin
            held = 1'b0;
         end
         tick();
      end
   endtask

   task automatic op1(input logic ta, input logic tb_v, input logic tc,
                      output int lat, output int nbusy, output logic [1:0] res);
      a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat = -1; nbusy = 0; res = 2'b00;
      for (int i = 0; i < 5; i++) begin
         if (busy1) nbusy++;
         if (done1 && lat < 0) begin
            lat = i; res = {cout1, s1[0]};
         end
         tick();
      end
   endtask

   initial begin
      int         lat, nbusy, ndone, ndone_rst;
      logic [7:0] rs, s_at_done;
      logic       rc, held, done_at;
      logic [1:0] res1;
      logic [1:0] exp1 [8];
      exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_s8",    32'(s8),    32'd0);
      check("rst_cout8", 32'(cout8), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      tick();

      // WIDTH=1: exhaustive full-adder truth table
      for (int v = 0; v < 8; v++) begin
         op1(v[2], v[1], v[0], lat, nbusy, res1);
         check($sformatf("w1_res_%0d", v), 32'(res1), 32'(exp1[v]));
         check($sformatf("w1_lat_%0d", v), 32'(lat),  32'd1);
         check($sformatf("w1_busy_%0d", v), 32'(nbusy), 32'd2);
      end

      // WIDTH=8 basic
      op8(8'h5A, 8'h3C, 1'b0, lat, nbusy, ndone, rs, rc, held);
      check("basic_s",     32'(rs),    32'h96);
      check("basic_cout",  32'(rc),    32'd0);
      check("basic_lat",   32'(lat),   32'd8);
      check("basic_ndone", 32'(ndone), 32'd1);
      check("basic_nbusy", 32'(nbusy), 32'd9);

      // Carry propagation
      op8(8'hFF, 8'h01, 1'b0, lat, nbusy, ndone, rs, rc, held);
      check("cprop1_s",    32'(rs), 32'h00);
      check("cprop1_cout", 32'(rc), 32'd1);
      op8(8'hFF, 8'hFF, 1'b1, lat, nbusy, ndone, rs, rc, held);
      check("cprop2_s",    32'(rs),   32'hFF);
      check("cprop2_cout", 32'(rc),   32'd1);
      check("cprop2_held", 32'(held), 32'd1);

      // Start held high while busy; the operands keep changing during RUN
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      tick();                              // edge k
      s_at_done = '0; done_at = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         a8 = a8 + 8'h11; b8 = b8 + 8'h23; cin8 = ~cin8;
         tick();                           // edge k+i
         if (i == 8) begin
            done_at = done8; s_at_done = s8;
         end
      end
      check("sbusy_done_k8", 32'(done_at),   32'd1);
      check("sbusy_s",       32'(s_at_done), 32'h46);
      check("sbusy_idle_k9", 32'(busy8),     32'd0);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
      tick();                              // edge k+10: accepted again
      start8 = 1'b0;
      check("sbusy_accept_k10", 32'(busy8), 32'd1);
      lat = -1;
      for (int i = 0; i < 14; i++) begin
         if (done8 && lat < 0) begin
            lat = i; rs = s8;
         end
         tick();
      end
      check("sbusy_second_lat", 32'(lat), 32'd8);
      check("sbusy_second_s",   32'(rs),  32'h02);

      // Reset mid-run at edge k+4
      a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
      tick();                              // edge k
      start8 = 1'b0;
      tick(); tick(); tick();              // edges k+1..k+3
      rst = 1'b1;
      tick();                              // edge k+4
      rst = 1'b0;
      check("mrst_busy", 32'(busy8), 32'd0);
      check("mrst_done", 32'(done8), 32'd0);
      check("mrst_s",    32'(s8),    32'd0);
      check("mrst_cout", 32'(cout8), 32'd0);
      ndone_rst = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) ndone_rst++;
         tick();
      end
      check("mrst_no_done", 32'(ndone_rst), 32'd0);
      op8(8'h01, 8'h02, 1'b0, lat, nbusy, ndone, rs, rc, held);
      check("mrst_fresh_s",    32'(rs),  32'h03);
      check("mrst_fresh_cout", 32'(rc),  32'd0);
      check("mrst_fresh_lat",  32'(lat), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences the team's single-bit full-adder cells (`sum1` for the sum bit, `carry1` for the carry bit) to add two WIDTH-bit operands, one bit per clock, LSB first. The block instantiates exactly one `sum1` and one `carry1`. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake. It sits between a requesting controller and the 1-bit adder datapath, and is the sequencing layer for multi-bit addition built from the 1-bit cells.

## Interface

- WIDTH, 8, operand/result width in bits; legal range ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; dominates every other input
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; sampled on the edge that accepts start
- b  in  WIDTH  operand B; sampled on the edge that accepts start
- cin  in  1  carry-in; sampled on the edge that accepts start
- busy  out  1  high in RUN and DONE states
- done  out  1  one-cycle pulse: result is valid
- s  out  WIDTH  sum result register
- cout  out  1  final carry-out register

## Operation

- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:**
  - start=1 at an edge: load sa←a, sb←b, carry←cin, cnt←0; go to RUN.
  - start=0: stay in IDLE.
- **RUN (one bit per edge):**
  - Cell inputs: `sum1`/`carry1` get a=sa[0], b=sb[0], c=carry.
  - Shifts: sa and sb shift right by 1. The `sum1` output s shifts into the MSB of an internal accumulator acc (acc shifts right). carry←`carry1` output z. cnt←cnt+1.
  - When cnt==WIDTH-1 at an edge: the bit is processed as above, and additionally s←final acc value (including this bit), cout←z, done←1, state→DONE.
- **DONE:** lasts exactly one cycle, with done=1. Next edge: done←0, state→IDLE.
- **Output holding:** s and cout change only on the RUN→DONE edge (or on reset). They hold the last result through IDLE and through the whole of the next RUN.
- **Widths:** cnt is $clog2(WIDTH)+1 bits wide and never wraps. Addition is modulo 2^WIDTH, and the overflow goes to cout. Operands are unsigned.
- **start while busy:** ignored, including start in the DONE cycle. Operands on a/b/cin are not re-sampled. The in-flight operation is unaffected.
- **a/b/cin changes during RUN:** no effect, because the operands are latched.
- **WIDTH=1:** RUN lasts one edge. The result equals the full-adder truth table.

## Timing

- Reset values after an edge with rst=1: state=IDLE, busy=0, done=0, s=0, cout=0, acc=0, sa=0, sb=0, carry=0, cnt=0.
- Reset mid-operation aborts RUN or DONE. No done pulse is produced for the aborted request.
- Let edge k accept start:
  - busy=1 from after edge k.
  - Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
  - done=1, with s/cout valid, in the cycle after edge k+WIDTH. Latency from start acceptance to done is WIDTH clocks.
  - busy=0 and done=0 after edge k+WIDTH+1.
- The earliest next accepted start is at edge k+WIDTH+2. Throughput is one addition per WIDTH+2 clocks.
- busy, done, s and cout are registered outputs with no combinational path from inputs. The only combinational paths are internal, through `sum1`/`carry1` into the carry and acc flops.

## Test plan

- **WIDTH=1, exhaustive:** all 8 {a,b,cin} combinations, 000 through 111 → {cout,s} = 00,01,01,10,01,10,10,11. done occurs 1 clock after start acceptance in each case.
- **WIDTH=8, basic:** a=0x5A, b=0x3C, cin=0 → s=0x96, cout=0. done is high for exactly 1 cycle, 8 clocks after acceptance. busy is high for 9 cycles.
- **WIDTH=8, carry propagation:** a=0xFF, b=0x01, cin=0 → s=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → s=0xFF, cout=1. s holds 0x00 throughout the second RUN until its done.
- **Start while busy:** start=1 held continuously, with a/b changing each cycle during RUN, starting from a=0x12, b=0x34. Result must be s=0x46 (first operands only). The next acceptance occurs at the edge k+10 (WIDTH+2).
- **Reset mid-run:** assert rst for one edge at k+4 of a 0x5A+0x3C add → the next cycle shows busy=0, done=0, s=0, cout=0. No done pulse ever appears. A fresh 0x01+0x02 request then gives s=0x03, cout=0.
